dino_runner: RTL and testbench

DINO_RUNNER -- requirements
Module: dino_runner

---
 rtl/dino_pkg.sv | 26 ++
 rtl/dino_lfsr.sv | 32 +++
 rtl/dino_runner.sv | 133 +++++++++++++
 tb/tb_dino_runner.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dino_pkg
// Purpose  : Shared constants for the dino runner game: LFSR geometry,
//            feedback taps, default seed and obstacle-spawn mode encodings.
// Revision : 1.0 - initial release
// ============================================================================
package dino_pkg;

    localparam int LFSR_W = 8;

    // Fibonacci taps 8,6,5,4 expressed as a bit mask over q[7:0]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

    localparam int OBS_MODE_LFSR  = 0;
    localparam int OBS_MODE_FIXED = 1;

    // Feedback bit: XOR of all tapped positions
    function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dino_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : dino_lfsr
// Purpose  : 8-bit Fibonacci LFSR that advances one step when en is high.
//            An all-zero seed would lock the register, so it becomes 8'h01.
// Revision : 1.0 - initial release
// ============================================================================
module dino_lfsr
    import dino_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] w_seed_safe;

    assign w_seed_safe = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

    // Shift left, feeding the tap XOR into bit 0
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= w_seed_safe;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], lfsr_feedback(q)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/dino_runner.sv
`default_nettype none
// ============================================================================
// Module   : dino_runner
// Purpose  : Two-row side-scrolling runner game. Obstacles scroll toward
//            column 0 once per game tick; the dino at column 0 jumps on a
//            rising edge of jmp and collides with an obstacle if grounded.
// Revision : 1.0 - initial release
// ============================================================================
module dino_runner
    import dino_pkg::*;
#(
    parameter int                COLS       = 8,
    parameter int                TICK_DIV   = 4,
    parameter int                JUMP_TICKS = 3,
    parameter int                OBS_MODE   = OBS_MODE_LFSR,
    parameter int                OBS_PERIOD = 12,
    parameter int                SCORE_W    = 8,
    parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 jmp,
    output logic [2*COLS-1:0]    grid_out,
    output logic                 game_over,
    output logic [SCORE_W-1:0]   score
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(JUMP_TICKS + 1);
    localparam int PW = (OBS_PERIOD > 1) ? $clog2(OBS_PERIOD) : 1;

    logic [TW-1:0]     r_tick_cnt;
    logic [COLS-1:0]   r_obs;
    logic [AW-1:0]     r_air_cnt;
    logic              r_jmp;
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_unused_lfsr;

    logic              w_tick;
    logic              w_spawn;
    logic [COLS-1:0]   w_obs_next;
    logic              w_grounded;
    logic              w_collide;
    logic              w_jump_accept;

    // A tick only fires while the game is live, so every tick-driven state
    // freezes automatically after a collision.
    assign w_tick        = (r_tick_cnt == TW'(TICK_DIV - 1)) && !game_over;
    assign w_obs_next    = {w_spawn, r_obs[COLS-1:1]};
    assign w_grounded    = (r_air_cnt == '0);
    // Collision uses the pre-tick air state: a jump launched on this same
    // edge is already too late.
    assign w_collide     = w_tick && w_obs_next[0] && w_grounded;
    assign w_jump_accept = jmp && !r_jmp && w_grounded && !game_over && !w_collide;

    dino_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    generate
        if (OBS_MODE == OBS_MODE_FIXED) begin : g_spawn_fixed
            logic [PW-1:0] r_period;
            logic          w_period_hit;

            assign w_period_hit  = (r_period == PW'(OBS_PERIOD - 1));
            assign w_spawn       = w_period_hit;
            assign w_unused_lfsr = ^w_lfsr;

            // Period counter: wraps to 0 on the tick that spawns
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_period <= '0;
                end else if (w_tick) begin
                    r_period <= w_period_hit ? '0 : r_period + PW'(1);
                end
            end
        end else begin : g_spawn_lfsr
            // Keep at least JUMP_TICKS empty columns behind the newest
            // obstacle so every obstacle can be cleared by a single jump.
            assign w_spawn       = (w_lfsr[1:0] == 2'b00) &&
                                   ~|r_obs[COLS-1 -: JUMP_TICKS+1];
            assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:2];
        end
    endgenerate

    // Clock divider producing the game tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!game_over) begin
            r_tick_cnt <= (r_tick_cnt == TW'(TICK_DIV - 1)) ? '0 : r_tick_cnt + TW'(1);
        end
    end

    // Game state: obstacles, jump timer, score and collision flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_obs     <= '0;
            r_air_cnt <= '0;
            r_jmp     <= 1'b0;
            score     <= '0;
            game_over <= 1'b0;
        end else begin
            r_jmp <= jmp;

            if (w_tick) begin
                r_obs <= w_obs_next;
                if (w_collide) begin
                    game_over <= 1'b1;
                end else if (score != '1) begin
                    score <= score + SCORE_W'(1);
                end
            end

            if (w_jump_accept) begin
                r_air_cnt <= AW'(JUMP_TICKS);
            end else if (w_tick && !w_grounded) begin
                r_air_cnt <= r_air_cnt - AW'(1);
            end
        end
    end

    // Display: lower row carries obstacles plus the grounded dino, upper row
    // carries the airborne dino at column 0 only.
    assign grid_out[COLS-1:0]      = r_obs | {{(COLS-1){1'b0}}, w_grounded};
    assign grid_out[2*COLS-1:COLS] = {{(COLS-1){1'b0}}, !w_grounded};

endmodule
`default_nettype wire

// File: tb/tb_dino_runner.sv
`default_nettype none
// ============================================================================
// Module   : tb_dino_runner
// Purpose  : Directed, table-driven bench for dino_runner in fixed-period
//            spawn mode (COLS=8, TICK_DIV=2, JUMP_TICKS=3, OBS_PERIOD=12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dino_runner;

    logic        clk;
    logic        reset;
    logic        jmp;
    logic [15:0] grid_out;
    logic        game_over;
    logic [7:0]  score;

    dino_runner #(
        .COLS       (8),
        .TICK_DIV   (2),
        .JUMP_TICKS (3),
        .OBS_MODE   (1),
        .OBS_PERIOD (12),
        .SCORE_W    (8),
        .SEED       (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .jmp       (jmp),
        .grid_out  (grid_out),
        .game_over (game_over),
        .score     (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_first;
        int          at_edge;
        bit          jmp_after;
        logic [15:0] grid;
        logic [7:0]  score;
        logic        go;
    } vec_t;

    vec_t vecs[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   edge_n     = 0;

    function automatic vec_t mk(bit r, int e, bit j, logic [15:0] g, logic [7:0] s, logic go);
        vec_t v;
        v.rst_first = r;
        v.at_edge   = e;
        v.jmp_after = j;
        v.grid      = g;
        v.score     = s;
        v.go        = go;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    task automatic check(string name, logic [15:0] g, logic [7:0] s, logic go);
        vectors++;
        if (grid_out !== g || score !== s || game_over !== go) begin
            miscompares++;
            $display("FAIL %s: got grid=%h score=%0d game_over=%b, want grid=%h score=%0d game_over=%b",
                     name, grid_out, score, game_over, g, s, go);
        end
    endtask

    initial begin
        reset = 1'b1;
        jmp   = 1'b0;

        // Scenario A: no jump, collision at tick 19 then frozen
        vecs.push_back(mk(1,  0, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0,  1, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0, 23, 0, 16'h0001, 11, 0));
        vecs.push_back(mk(0, 24, 0, 16'h0081, 12, 0));
        vecs.push_back(mk(0, 26, 0, 16'h0041, 13, 0));
        vecs.push_back(mk(0, 36, 0, 16'h0003, 18, 0));
        vecs.push_back(mk(0, 38, 0, 16'h0001, 18, 1));
        vecs.push_back(mk(0, 58, 0, 16'h0001, 18, 1));
        // Scenario B: one-cycle pulse sampled at edge 33 clears the obstacle
        vecs.push_back(mk(1,  0, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0, 32, 1, 16'h0009, 16, 0));
        vecs.push_back(mk(0, 33, 0, 16'h0108, 16, 0));
        vecs.push_back(mk(0, 34, 0, 16'h0104, 17, 0));
        vecs.push_back(mk(0, 37, 0, 16'h0102, 18, 0));
        vecs.push_back(mk(0, 38, 0, 16'h0001, 19, 0));
        vecs.push_back(mk(0, 40, 0, 16'h0001, 20, 0));
        // Scenario C: jmp held 33..60 gives one jump only; next obstacle hits
        vecs.push_back(mk(1,  0, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0, 32, 1, 16'h0009, 16, 0));
        vecs.push_back(mk(0, 33, 1, 16'h0108, 16, 0));
        vecs.push_back(mk(0, 38, 1, 16'h0001, 19, 0));
        vecs.push_back(mk(0, 50, 1, 16'h0041, 25, 0));
        vecs.push_back(mk(0, 60, 0, 16'h0003, 30, 0));
        vecs.push_back(mk(0, 62, 0, 16'h0001, 30, 1));
        vecs.push_back(mk(0, 63, 1, 16'h0001, 30, 1));
        vecs.push_back(mk(0, 64, 0, 16'h0001, 30, 1));
        // Scenario D: pulse on the collision edge does not launch a jump
        vecs.push_back(mk(1,  0, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0, 37, 1, 16'h0003, 18, 0));
        vecs.push_back(mk(0, 38, 0, 16'h0001, 18, 1));
        vecs.push_back(mk(0, 40, 0, 16'h0001, 18, 1));
        // Scenario E: reset at edge 35 mid-jump restarts the schedule
        vecs.push_back(mk(1,  0, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0, 32, 1, 16'h0009, 16, 0));
        vecs.push_back(mk(0, 33, 0, 16'h0108, 16, 0));
        vecs.push_back(mk(0, 34, 0, 16'h0104, 17, 0));
        vecs.push_back(mk(1,  0, 0, 16'h0001,  0, 0));
        vecs.push_back(mk(0, 23, 0, 16'h0001, 11, 0));
        vecs.push_back(mk(0, 24, 0, 16'h0081, 12, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            while (edge_n < vecs[i].at_edge) step();
            check($sformatf("vec%0d@e%0d", i, vecs[i].at_edge),
                  vecs[i].grid, vecs[i].score, vecs[i].go);
            jmp = vecs[i].jmp_after;
        end

        // Reset held with jmp toggling: outputs stay at the reset image
        jmp   = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            jmp = ~jmp;
            @(posedge clk);
            #1;
            check($sformatf("rst_hold%0d", k), 16'h0001, 8'd0, 1'b0);
        end
        reset  = 1'b0;
        jmp    = 1'b0;
        edge_n = 0;

        // Re-jump: accept at edge 1, hold high until edge 10, fall, rise at 12
        jmp = 1'b1;
        step();
        check("rejmp_launch", 16'h0100, 8'd0, 1'b0);
        while (edge_n < 6) step();
        check("rejmp_landed", 16'h0001, 8'd3, 1'b0);
        for (int e = 7; e <= 10; e++) begin
            step();
            check($sformatf("rejmp_held_e%0d", e), 16'h0001, 8'(e / 2), 1'b0);
        end
        jmp = 1'b0;
        step();
        check("rejmp_fall", 16'h0001, 8'd5, 1'b0);
        jmp = 1'b1;
        step();
        check("rejmp_rise", 16'h0100, 8'd6, 1'b0);
        jmp = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
